// File: rtl/audio_i2s_tx.sv
// I2S transmitter: samples are truncated, attenuated, optionally mono-mixed, then sent MSB-first, left-justified.
// Latency: 1 clk conditioning, frame latched on each wrap of the bit counter; no backpressure, sample_req paces the source.
module audio_i2s_tx #(
  parameter int IN_W       = 18,
  parameter int OUT_W      = 16,
  parameter int STEREO     = 1,
  parameter int OFFSET_BIN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [7:0]      div,
  input  logic [1:0]      volume,
  input  logic [IN_W-1:0] audio_l,
  input  logic [IN_W-1:0] audio_r,
  output logic            sample_req,
  output logic            hp_bck,
  output logic            hp_ws,
  output logic            hp_din,
  output logic            pa_en
);
  localparam int            BITS    = 2 * OUT_W;
  localparam int            CW      = $clog2(BITS);
  localparam logic [CW-1:0] LAST    = CW'(BITS - 1);
  localparam logic [CW-1:0] HALF    = CW'(OUT_W);
  localparam logic          MSB_INV = (OFFSET_BIN != 0);

  logic signed [OUT_W-1:0] cond_l_q, cond_r_q;
  logic signed [OUT_W-1:0] vol_l, vol_r;
  logic signed [OUT_W:0]   mix_sum;
  logic signed [OUT_W-1:0] mix_sat;
  logic [OUT_W-1:0]        slot_l, slot_r;
  logic [BITS-1:0]         frame;

  logic [7:0]       div_cnt_q, div_cnt_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             bck_q, bck_d;
  logic             ws_q, ws_d;
  logic             din_q, din_d;
  logic             req_q, req_d;
  logic             pa_en_q;
  logic [OUT_W-1:0] hold_l_q, hold_l_d;
  logic [OUT_W-1:0] hold_r_q, hold_r_d;

  function automatic logic signed [OUT_W-1:0] atten(input logic signed [OUT_W-1:0] x,
                                                    input logic [1:0] v);
    case (v)
      2'd0:    atten = '0;
      2'd1:    atten = x >>> 2;
      2'd2:    atten = x >>> 1;
      default: atten = x;
    endcase
  endfunction

  always_comb begin
    vol_l   = atten(cond_l_q, volume);
    vol_r   = atten(cond_r_q, volume);
    mix_sum = {vol_l[OUT_W-1], vol_l} + {vol_r[OUT_W-1], vol_r};
    // Overflow shows up as the two top bits of the widened sum disagreeing.
    if (mix_sum[OUT_W] != mix_sum[OUT_W-1])
      mix_sat = {mix_sum[OUT_W], {(OUT_W-1){~mix_sum[OUT_W]}}};
    else
      mix_sat = mix_sum[OUT_W-1:0];
    if (STEREO != 0) begin
      slot_l = vol_l;
      slot_r = vol_r;
    end else begin
      slot_l = mix_sat;
      slot_r = mix_sat;
    end
    slot_l[OUT_W-1] = slot_l[OUT_W-1] ^ MSB_INV;
    slot_r[OUT_W-1] = slot_r[OUT_W-1] ^ MSB_INV;
  end

  assign frame = {hold_l_q, hold_r_q};

  always_comb begin
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    bck_d     = bck_q;
    ws_d      = ws_q;
    din_d     = din_q;
    req_d     = 1'b0;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    if (!enable) begin
      div_cnt_d = '0;
      bit_cnt_d = LAST;
      bck_d     = 1'b0;
      ws_d      = 1'b0;
      din_d     = 1'b0;
    end else if (div_cnt_q >= div) begin
      div_cnt_d = '0;
      bck_d     = ~bck_q;
      if (bck_q) begin
        if (bit_cnt_q == LAST) begin
          // Holding registers load in the same clk, so bit 0 comes straight from the new slot.
          bit_cnt_d = '0;
          hold_l_d  = slot_l;
          hold_r_d  = slot_r;
          req_d     = 1'b1;
          ws_d      = 1'b0;
          din_d     = slot_l[OUT_W-1];
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
          ws_d      = (bit_cnt_d >= HALF);
          din_d     = frame[LAST - bit_cnt_d];
        end
      end
    end else begin
      div_cnt_d = div_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cond_l_q  <= '0;
      cond_r_q  <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= LAST;
      bck_q     <= 1'b0;
      ws_q      <= 1'b0;
      din_q     <= 1'b0;
      req_q     <= 1'b0;
      pa_en_q   <= 1'b0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
    end else begin
      cond_l_q  <= audio_l[IN_W-1 -: OUT_W];
      cond_r_q  <= audio_r[IN_W-1 -: OUT_W];
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bck_q     <= bck_d;
      ws_q      <= ws_d;
      din_q     <= din_d;
      req_q     <= req_d;
      pa_en_q   <= enable;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
    end
  end

  assign sample_req = req_q;
  assign hp_bck     = bck_q;
  assign hp_ws      = ws_q;
  assign hp_din     = din_q;
  assign pa_en      = pa_en_q;
endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: a stereo/two's-complement and a mono/offset-binary instance share stimulus;
// serial frames are captured and compared with an arithmetic reference of the sample path.
module tb_audio_i2s_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable;
  logic [7:0]  div;
  logic [1:0]  volume;
  logic [17:0] audio_l, audio_r;
  logic req_st, bck_st, ws_st, din_st, pa_st;
  logic req_mo, bck_mo, ws_mo, din_mo, pa_mo;

  int checks   = 0;
  int failures = 0;

  audio_i2s_tx #(.IN_W(18), .OUT_W(16), .STEREO(1), .OFFSET_BIN(0)) u_st (
    .clk(clk), .reset(reset), .enable(enable), .div(div), .volume(volume),
    .audio_l(audio_l), .audio_r(audio_r), .sample_req(req_st), .hp_bck(bck_st),
    .hp_ws(ws_st), .hp_din(din_st), .pa_en(pa_st));

  audio_i2s_tx #(.IN_W(18), .OUT_W(16), .STEREO(0), .OFFSET_BIN(1)) u_mo (
    .clk(clk), .reset(reset), .enable(enable), .div(div), .volume(volume),
    .audio_l(audio_l), .audio_r(audio_r), .sample_req(req_mo), .hp_bck(bck_mo),
    .hp_ws(ws_mo), .hp_din(din_mo), .pa_en(pa_mo));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference sample path: 18-bit signed value -> floor(x/4), then volume as a floor-scaled fraction.
  function automatic int cond_ref(input logic [17:0] a);
    int v;
    v = $signed({{14{a[17]}}, a});
    return v >>> 2;
  endfunction

  function automatic int vol_ref(input int c, input logic [1:0] v);
    case (v)
      2'd0:    return 0;
      2'd1:    return c >>> 2;
      2'd2:    return c >>> 1;
      default: return c;
    endcase
  endfunction

  int          idx = 0;
  bit          mon_act = 1'b0;
  logic        prev_bck = 1'b0;
  logic [31:0] sh_st, sh_mo, sh_ws, exp_st, exp_mo;
  logic [31:0] last_st = '0, last_mo = '0;

  always @(negedge clk) begin : monitor
    int l, r, m;
    if (reset || !enable) begin
      mon_act  = 1'b0;
      prev_bck = 1'b0;
    end else begin
      if (bck_st && !prev_bck && mon_act && idx < 32) begin
        sh_st = {sh_st[30:0], din_st};
        sh_mo = {sh_mo[30:0], din_mo};
        sh_ws = {sh_ws[30:0], ws_st};
        idx++;
        if (idx == 32) begin
          check("frame_stereo", sh_st, exp_st);
          check("frame_mono", sh_mo, exp_mo);
          check("ws_pattern", sh_ws, 32'h0000FFFF);
          last_st = sh_st;
          last_mo = sh_mo;
        end
      end
      if (req_st) begin
        if (mon_act) check("frame_len", 32'(idx), 32'd32);
        l = vol_ref(cond_ref(audio_l), volume);
        r = vol_ref(cond_ref(audio_r), volume);
        exp_st = {16'(l), 16'(r)};
        m = l + r;
        if (m > 32767)  m = 32767;
        if (m < -32768) m = -32768;
        m = m + 32768;
        exp_mo  = {16'(m), 16'(m)};
        idx     = 0;
        mon_act = 1'b1;
      end
      prev_bck = bck_st;
    end
  end

  task automatic wait_req(input string tag);
    int k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!req_st && k < 1000);
    check(tag, 32'(req_st), 32'd1);
  endtask

  // New stimulus is applied just after a latch so it belongs wholly to the next frame.
  task automatic apply(input logic [17:0] l, input logic [17:0] r, input logic [1:0] v,
                       input logic [7:0] d);
    wait_req("apply_req");
    @(negedge clk); #1;
    audio_l = l;
    audio_r = r;
    volume  = v;
    div     = d;
  endtask

  task automatic half_period(output int n);
    logic b0;
    int   k = 0;
    b0 = bck_st;
    while (bck_st == b0 && k < 600) begin @(posedge clk); #1; k++; end
    b0 = bck_st;
    n  = 0;
    while (bck_st == b0 && n < 600) begin @(posedge clk); #1; n++; end
  endtask

  // Edges after the first enabled edge until sample_req is seen, counting din activity before it.
  task automatic count_to_req(output int n, output int bad);
    n   = 0;
    bad = 0;
    while (!req_st && n < 1000) begin
      if (din_st || din_mo) bad++;
      @(posedge clk); #1; n++;
    end
  endtask

  function automatic logic [17:0] rand_smp();
    case ($urandom_range(0, 3))
      0:       return 18'h1FFFF;
      1:       return 18'h20000;
      default: return 18'($urandom);
    endcase
  endfunction

  logic [15:0] vol_exp [3] = '{16'h1234, 16'h2468, 16'h0000};
  logic [1:0]  vol_set [3] = '{2'd1, 2'd2, 2'd0};

  initial begin
    int n, bad;
    reset = 1'b1; enable = 1'b1; div = 8'd3; volume = 2'd3;
    audio_l = 18'h12344; audio_r = 18'h3FFFC;
    repeat (2) begin @(posedge clk); #1; end
    check("rst_bck", 32'(bck_st), 0);
    check("rst_ws", 32'(ws_st), 0);
    check("rst_din", 32'(din_st), 0);
    check("rst_req", 32'(req_st), 0);
    check("rst_pa_en", 32'({pa_st, pa_mo}), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("pa_en_release", 32'({pa_st, pa_mo}), 32'd3);
    // First falling bck (and latch) lands 2*(div+1) edges after release, counting the release edge.
    count_to_req(n, bad);
    check("first_req_latency", 32'(n), 32'd7);
    check("din_before_first_req", 32'(bad), 0);
    half_period(n);
    check("half_period_div3", 32'(n), 32'd4);
    wait_req("req2");
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!req_st && n < 1000);
    check("req_period", 32'(n), 32'd256);
    check("stereo_frame_const", last_st, 32'h48D1FFFF);
    check("mono_frame_const", last_mo, 32'hC8D0C8D0);

    apply(18'h1FFFC, 18'h1FFFC, 2'd3, 8'd3);
    wait_req("sat_a"); wait_req("sat_b");
    check("mono_sat_pos", last_mo, 32'hFFFFFFFF);
    check("stereo_pos_fs", last_st, 32'h7FFF7FFF);
    apply(18'h20000, 18'h20000, 2'd3, 8'd3);
    wait_req("sat_c"); wait_req("sat_d");
    check("mono_sat_neg", last_mo, 32'h00000000);
    check("stereo_neg_fs", last_st, 32'h80008000);

    for (int i = 0; i < 3; i++) begin
      apply(18'h12344, 18'h3FFFC, vol_set[i], 8'd3);
      wait_req("vol_a"); wait_req("vol_b");
      check($sformatf("volume%0d_left", vol_set[i]), 32'(last_st[31:16]), 32'(vol_exp[i]));
    end

    for (int i = 0; i < 24; i++)
      apply(rand_smp(), rand_smp(), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 4)));
    wait_req("rand_a"); wait_req("rand_b");

    apply(18'h0AAAA, 18'h35555, 2'd3, 8'd3);
    wait_req("divchg_a");
    repeat (40) @(posedge clk);
    #1; div = 8'd1;
    for (int i = 0; i < 3; i++) begin
      half_period(n);
      check("half_period_div1", 32'(n), 32'd2);
    end
    wait_req("divchg_b"); wait_req("divchg_c");

    apply(18'h15A5A, 18'h2C3C3, 2'd3, 8'd3);
    wait_req("en_a");
    n = 0;
    while (!ws_st && n < 1000) begin @(posedge clk); #1; n++; end
    check("right_slot_reached", 32'(ws_st), 32'd1);
    repeat (3) @(posedge clk);
    #1; enable = 1'b0;
    @(posedge clk); #1;
    check("dis_outputs", 32'({bck_st, ws_st, din_st, req_st}), 0);
    check("dis_pa_en", 32'(pa_st), 0);
    repeat (5) @(posedge clk);
    #1; enable = 1'b1;
    @(posedge clk); #1;
    count_to_req(n, bad);
    check("reenable_req_latency", 32'(n), 32'd7);
    check("din_before_reenable_req", 32'(bad), 0);
    wait_req("en_b"); wait_req("en_c");

    repeat (100) @(posedge clk);
    #1; reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("midrst_outputs", 32'({bck_st, ws_st, din_st, req_st, pa_st}), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    count_to_req(n, bad);
    check("midrst_req_latency", 32'(n), 32'd7);
    check("din_after_midrst", 32'(bad), 0);
    wait_req("rst_b"); wait_req("rst_c");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
